// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath. Walks one instruction at a time
// through fetch/decode/execute/memory/writeback, selects the next PC, handshakes with
// data memory and latches the processor status, stopping on halt or fault.
module seq_stage_controller #(
  parameter logic [63:0] ResetPc    = 64'h0,
  parameter int unsigned MemTimeout = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic        cnd_i,
  input  logic        halt_i,
  input  logic        mem_error_i,
  input  logic        func_error_i,
  input  logic [63:0] valc_i,
  input  logic [63:0] valp_i,
  input  logic [63:0] valm_i,
  input  logic        mem_ready_i,
  input  logic        dmem_error_i,
  output logic [63:0] pc_o,
  output logic        fetch_en_o,
  output logic        decode_en_o,
  output logic        execute_en_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic        cc_en_o,
  output logic [2:0]  stat_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] instr_count_o
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcUpd, StHalted
  } state_e;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  // Wait-counter value seen during the last permitted MEMORY cycle.
  localparam logic [31:0] WaitLast = (MemTimeout == 0) ? 32'd0 : 32'(MemTimeout - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] valp_q, valp_d;
  logic [63:0] valm_q, valm_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q, cnd_d;
  logic [2:0]  stat_q, stat_d;
  logic [31:0] count_q, count_d;
  logic [31:0] wait_q, wait_d;

  logic fetch_en_q, fetch_en_d;
  logic decode_en_q, decode_en_d;
  logic execute_en_q, execute_en_d;
  logic mem_en_q, mem_en_d;
  logic wb_en_q, wb_en_d;
  logic cc_en_q, cc_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic        needs_mem;
  logic [63:0] next_pc;

  // Instruction class and next-PC selection from the latched fetch results.
  always_comb begin
    needs_mem = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    case (icode_q)
      4'h8:    next_pc = valc_q;
      4'h7:    next_pc = cnd_q ? valc_q : valp_q;
      4'h9:    next_pc = valm_q;
      default: next_pc = valp_q;
    endcase
  end

  // Next-state, datapath latches and registered Moore outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    valm_d  = valm_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    stat_d  = stat_q;
    count_d = count_q;
    wait_d  = wait_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        if (mem_error_i) begin
          stat_d  = StatAdr;
          state_d = StHalted;
        end else if (func_error_i) begin
          stat_d  = StatIns;
          state_d = StHalted;
        end else if (halt_i) begin
          stat_d  = StatHlt;
          state_d = StHalted;
        end else begin
          icode_d = icode_i;
          valc_d  = valc_i;
          valp_d  = valp_i;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        cnd_d = cnd_i;
        if (needs_mem) begin
          wait_d  = 32'd0;
          state_d = StMemory;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        // A ready on the final permitted cycle still wins over the timeout.
        if (mem_ready_i) begin
          if (dmem_error_i) begin
            stat_d  = StatAdr;
            state_d = StHalted;
          end else begin
            valm_d  = valm_i;
            state_d = StWriteback;
          end
        end else if (MemTimeout != 0 && wait_q == WaitLast) begin
          stat_d  = StatAdr;
          state_d = StHalted;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      StWriteback: state_d = StPcUpd;
      StPcUpd: begin
        pc_d    = next_pc;
        count_d = count_q + 32'd1;
        state_d = StFetch;
      end
      StHalted: state_d = StHalted;
    endcase

    // Outputs are decoded one cycle early so they leave flops aligned with the state.
    fetch_en_d   = (state_d == StFetch);
    decode_en_d  = (state_d == StDecode);
    execute_en_d = (state_d == StExecute);
    mem_en_d     = (state_d == StMemory);
    cc_en_d      = (state_d == StExecute) && (icode_d == 4'h6);
    wb_en_d      = (state_d == StWriteback) &&
                   ((icode_d inside {4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ||
                    (icode_d == 4'h2 && cnd_d));
    busy_d       = (state_d != StIdle) && (state_d != StHalted);
    done_d       = (state_d == StHalted);
  end

  // All sequencer state, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pc_q         <= ResetPc;
      valc_q       <= 64'd0;
      valp_q       <= 64'd0;
      valm_q       <= 64'd0;
      icode_q      <= 4'd0;
      cnd_q        <= 1'b0;
      stat_q       <= StatAok;
      count_q      <= 32'd0;
      wait_q       <= 32'd0;
      fetch_en_q   <= 1'b0;
      decode_en_q  <= 1'b0;
      execute_en_q <= 1'b0;
      mem_en_q     <= 1'b0;
      wb_en_q      <= 1'b0;
      cc_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valc_q       <= valc_d;
      valp_q       <= valp_d;
      valm_q       <= valm_d;
      icode_q      <= icode_d;
      cnd_q        <= cnd_d;
      stat_q       <= stat_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      fetch_en_q   <= fetch_en_d;
      decode_en_q  <= decode_en_d;
      execute_en_q <= execute_en_d;
      mem_en_q     <= mem_en_d;
      wb_en_q      <= wb_en_d;
      cc_en_q      <= cc_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pc_o          = pc_q;
  assign stat_o        = stat_q;
  assign instr_count_o = count_q;
  assign fetch_en_o    = fetch_en_q;
  assign decode_en_o   = decode_en_q;
  assign execute_en_o  = execute_en_q;
  assign mem_en_o      = mem_en_q;
  assign wb_en_o       = wb_en_q;
  assign cc_en_o       = cc_en_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle sequencer for the Y86-64 SEQ datapath. Steps the fetch, decode, execute, memory and register-writeback blocks through one instruction at a time with per-stage enables. Selects and registers the next PC, and handshakes with data memory. Latches the processor status (AOK/HLT/ADR/INS) and stops on halt or fault.

## Interface
Parameters:
- RESET_PC, 64'h0: PC loaded on reset.
- MEM_TIMEOUT, 15: maximum cycles in MEMORY awaiting mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE when high.
- icode  in  4  from fetch.
- cnd  in  1  branch/cmov condition from execute.
- halt  in  1  fetch flags a halt instruction.
- mem_error  in  1  fetch: instruction address invalid.
- func_error  in  1  fetch: invalid icode/ifun.
- valC  in  64  constant word from fetch.
- valP  in  64  fall-through PC from fetch.
- valM  in  64  data read from memory.
- mem_ready  in  1  data-memory access complete.
- dmem_error  in  1  data-memory address fault; valid with mem_ready.
- PC  out  64  current instruction address, drives fetch.
- fetch_en, decode_en, execute_en, mem_en, wb_en  out  1 each  stage enables.
- cc_en  out  1  condition-code register load.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  high outside IDLE and HALTED.
- done  out  1  high in HALTED.
- instr_count  out  32  retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED. All outputs are Moore outputs decoded from the registered state.
- IDLE: goes to FETCH when start=1; otherwise holds.
- FETCH (fetch_en=1): at the closing edge, checks fault inputs in priority order:
  - mem_error: stat=ADR, go to HALTED.
  - func_error: stat=INS, go to HALTED.
  - halt: stat=HLT, go to HALTED.
  - otherwise: latch icode, valC and valP, then go to DECODE.
- DECODE (decode_en=1): go to EXECUTE.
- EXECUTE (execute_en=1): cc_en=1 only when latched icode=6 (OPq). Latch cnd.
  - icode in {4,5,8,9,A,B}: go to MEMORY.
  - otherwise: go to WRITEBACK.
- MEMORY (mem_en=1, held until exit):
  - mem_ready=1 and dmem_error=0: latch valM, go to WRITEBACK.
  - mem_ready=1 and dmem_error=1: stat=ADR, go to HALTED.
  - Wait counter reaches MEM_TIMEOUT without mem_ready (MEM_TIMEOUT>0): stat=ADR, go to HALTED.
- WRITEBACK (wb_en=1 for icode in {3,5,6,8,9,A,B}, or icode=2 with latched cnd=1): go to PCUPD.
- PCUPD: PC loads the next PC, instr_count increments, then go to FETCH. Next PC by icode:
  - 8 (call): valC.
  - 7 (jXX): valC if cnd=1, else valP.
  - 9 (ret): valM.
  - all others: valP.
- HALTED: absorbing; only reset exits. PC frozen at the faulting or halt instruction. start ignored. All enables 0.
- instr_count wraps modulo 2^32. Halt and faulted instructions are not counted.

## Timing
- Reset values (immediate on rst_n low, independent of clk):
  - state=IDLE, PC=RESET_PC, stat=1, instr_count=0.
  - All enables 0, busy=0, done=0.
  - Latches and the wait counter cleared.
- Reset asserted in any state, including mid-MEMORY, aborts the instruction: no PC update, no count.
- start sampled high at edge N: FETCH during cycle N+1.
- Latency per instruction:
  - Non-memory: 5 cycles (FETCH, DECODE, EXECUTE, WRITEBACK, PCUPD).
  - Memory: 6 cycles plus k, where k = cycles in MEMORY before mem_ready.
- mem_ready high in the first MEMORY cycle gives k=0. mem_en is high for k+1 cycles.
- The wait counter clears on MEMORY entry. With MEM_TIMEOUT=T, the fault is taken at the edge ending the T-th MEMORY cycle if mem_ready was never high.
- mem_ready=1 on the timeout cycle counts as success.
- stat and done update at the same edge that enters HALTED.
- The new PC is visible in the first cycle of the next FETCH.

## Test plan
- Reset/start: rst_n=0 mid-run gives PC=0, stat=1, busy=0 immediately. Release, start=1: fetch_en=1 one cycle later.
- OPq: icode=6, valP=2 gives enables fetch, decode, execute+cc_en, wb_en in sequence, then PC=2 and instr_count=1 after 5 cycles.
- Jump, cnd=1: icode=7, valC=0x40 gives PC=0x40.
- Jump, cnd=0: icode=7, valP=9 gives PC=9, and wb_en stays 0.
- Memory: mrmovq (icode=5) with mem_ready after 3 wait cycles holds mem_en for 4 cycles; total 9 cycles, wb_en=1. Then ret (icode=9), valM=0x100, gives PC=0x100.
- Faults:
  - halt=1: stat=2, done=1, PC unchanged, start ignored.
  - func_error=1: stat=4.
  - mem_error=1 and func_error=1 together: stat=3.
  - pushq (icode=A) with mem_ready held low, MEM_TIMEOUT=15: stat=3 after exactly 15 MEMORY cycles.
  - dmem_error=1 with mem_ready=1: stat=3, no writeback.
- Async reset pulsed mid-MEMORY (no clock edge): all outputs at reset values immediately. Next start resumes from RESET_PC with instr_count=0.
